// File: rtl/uart_rx.sv
`default_nettype none
// uart_rx: 8N1 UART receiver with 2-FF synchroniser, 3-sample majority voting and a
// valid/ready holding register. Define UART_RX_PARITY_EN for 8E1 frames with parity_err.
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_DIVISOR = BAUD_DIVISOR / 2;
    localparam int CNT_W        = $clog2(BAUD_DIVISOR);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIVISOR - 1);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(HALF_DIVISOR - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(HALF_DIVISOR);
    localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(HALF_DIVISOR + 1);
    // The start edge reaches the FSM two clocks late through the synchroniser;
    // starting the counter at 2 keeps the sample window centred on the line's mid-bit.
    localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(2);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       smp_q, smp_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             maj, decide;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             perr_q, perr_d;
`endif

    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    assign decide  = (cnt_q == SMP_C);
    assign cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        smp_d   = smp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (cnt_q == SMP_A) begin
            smp_d[0] = rx_s_q;
        end
        if (cnt_q == SMP_B) begin
            smp_d[1] = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = CNT_SYNC;
                end
            end
            S_START: begin
                cnt_d = cnt_inc;
                if (decide) begin
                    if (maj) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                cnt_d = cnt_inc;
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_d = cnt_inc;
                if (decide) begin
                    par_bad_d = maj ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                cnt_d = cnt_inc;
                if (decide) begin
                    cnt_d = '0;
                    if (maj) begin
                        state_d = S_IDLE;
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        perr_d = par_bad_q;
`endif
                    end else begin
                        state_d = S_WAIT_IDLE;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // A break must give way to a full bit period of idle before re-arming.
                if (!rx_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            smp_q     <= 2'b11;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            smp_q     <= smp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx: directed scenarios plus randomized frames for uart_rx, checked against
// a byte-queue model of what the holding register must present.
module tb_uart_rx;

    localparam int BD   = 27000000 / 115200;
    localparam int HALF = BD / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
    localparam int LAT   = 10 * BD + HALF + 1;
`else
    localparam int NBITS = 10;
    localparam int LAT   = 9 * BD + HALF + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err, busy;

    uart_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model: bytes that must appear, in order, plus expected error-pulse counts
    logic [7:0] exp_q[$];
    int exp_ferr = 0, exp_ovr = 0, exp_par = 0;
    int ferr_cnt = 0, ovr_cnt = 0, par_cnt = 0;
    int loads = 0, load_cyc = 0, edge_cyc = 0, meas_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_frame_err_cnt"}, 32'(ferr_cnt), 32'(exp_ferr));
        check({tag, "_overrun_cnt"}, 32'(ovr_cnt), 32'(exp_ovr));
        check({tag, "_parity_err_cnt"}, 32'(par_cnt), 32'(exp_par));
    endtask

    // compare process: every cycle, outputs against the byte-queue model
    logic       pv = 1'b0, pf = 1'b0, po = 1'b0, pp = 1'b0, hs;
    logic [7:0] pd = 8'h00;
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            check("rst_rx_valid", 32'(rx_valid), 0);
            check("rst_rx_data", 32'(rx_data), 0);
            check("rst_frame_err", 32'(frame_err), 0);
            check("rst_overrun", 32'(overrun), 0);
            check("rst_parity_err", 32'(parity_err), 0);
            check("rst_busy", 32'(busy), 0);
            pv = 1'b0; pd = 8'h00; pf = 1'b0; po = 1'b0; pp = 1'b0;
        end else begin
            hs = pv && rx_ready;
            if (pv && !hs) begin
                check("valid_held", 32'(rx_valid), 1);
                check("data_stable", 32'(rx_data), 32'(pd));
            end else if (rx_valid) begin
                loads++;
                load_cyc = cyc;
                check("byte_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (frame_err) begin ferr_cnt++; check("frame_err_width", 32'(pf), 0); end
            if (overrun)   begin ovr_cnt++;  check("overrun_width", 32'(po), 0); end
            if (parity_err) begin par_cnt++; check("parity_err_width", 32'(pp), 0); end
            pv = rx_valid; pd = rx_data; pf = frame_err; po = overrun; pp = parity_err;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; abort_bit >= 0 resets the DUT mid-way through that data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par,
                              input int blen, input int abort_bit);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9]   = (^b) ^ bad_par;
        bits[10]  = stop;
`else
        bits[9]   = stop;
`endif
        edge_cyc = cyc;
        for (int i = 0; i < NBITS; i++) begin
            rx = bits[i];
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                repeat (blen / 2) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check("midrst_rx_valid", 32'(rx_valid), 0);
                check("midrst_busy", 32'(busy), 0);
                check("midrst_rx_data", 32'(rx_data), 0);
                repeat (4) @(negedge clk);
                rx    = 1'b1;
                rst_n = 1'b1;
                return;
            end
            repeat (blen) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    initial begin
        int l0, nb, t, blen;
        logic [7:0] b;
        logic stop, bp;

        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        // back-to-back 0x55, 0xA3 with latency checks
        rx_ready = 1'b1;
        l0 = loads;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3);
        send_frame(8'h55, 1'b1, 1'b0, BD, -1);
        meas_lat = load_cyc - edge_cyc;
        check_range("latency_55", meas_lat, LAT - 3, LAT + 3);
        send_frame(8'hA3, 1'b1, 1'b0, BD, -1);
        check_range("latency_a3", load_cyc - edge_cyc, LAT - 3, LAT + 3);
        idle(20);
        check("t1_loads", 32'(loads - l0), 2);
        check("t1_last_data", 32'(rx_data), 32'h0000_00A3);
        check_errs("t1");

        // start-bit glitch: 50 clocks low
        l0 = loads;
        nb = 0;
        rx = 1'b0;
        for (int i = 0; i < 450; i++) begin
            if (i == 50) rx = 1'b1;
            @(negedge clk);
            if (busy) nb++;
        end
        check_range("glitch_busy_clocks", nb, 1, 120);
        check("glitch_busy_end", 32'(busy), 0);
        check("glitch_loads", 32'(loads - l0), 0);
        check_errs("glitch");

        // framing error, then recovery after a full idle bit
        l0 = loads;
        send_frame(8'h3C, 1'b0, 1'b0, BD, -1);
        exp_ferr++;
        idle(300);
        check("ferr_no_byte", 32'(loads - l0), 0);
        check_errs("ferr");
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0, BD, -1);
        idle(5);
        check("ferr_recover_loads", 32'(loads - l0), 1);
        check("ferr_recover_data", 32'(rx_data), 32'h0000_007E);

        // overrun with consumer stalled
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, BD, -1);
        send_frame(8'h22, 1'b1, 1'b0, BD, -1);
        exp_ovr++;
        idle(5);
        check("ovr_data", 32'(rx_data), 32'h0000_0011);
        check("ovr_valid", 32'(rx_valid), 1);
        check_errs("ovr");
        rx_ready = 1'b1;
        idle(3);
        rx_ready = 1'b0;
        check("ovr_drained", 32'(rx_valid), 0);

        // consumer accepts in the very cycle the next byte completes
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, BD, -1);
        idle(5);
        exp_q.push_back(8'h22);
        t = cyc + meas_lat - 1;
        fork
            send_frame(8'h22, 1'b1, 1'b0, BD, -1);
            begin
                while (cyc < t) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        idle(5);
        check("samecyc_data", 32'(rx_data), 32'h0000_0022);
        check("samecyc_valid", 32'(rx_valid), 1);
        check("samecyc_queue", 32'(exp_q.size()), 0);
        check_errs("samecyc");
        rx_ready = 1'b1;
        idle(3);

        // reset during data bit 4 of 0xF0, then 0x0F
        l0 = loads;
        send_frame(8'hF0, 1'b1, 1'b0, BD, 4);
        idle(300);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0, BD, -1);
        idle(5);
        check("rst_loads", 32'(loads - l0), 1);
        check("rst_then_data", 32'(rx_data), 32'h0000_000F);
        check_errs("rst");

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0, BD, -1);
        idle(5);
        check_errs("par_good");
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, BD, -1);
        exp_par++;
        idle(5);
        check("par_bad_data", 32'(rx_data), 32'h0000_0007);
        check_errs("par_bad");
`endif

        // randomized frames: data, +/-3% bit length, occasional bad stop, gaps incl. none
        for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom);
            blen = $urandom_range(BD - 7, BD + 7);
            stop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            bp = ($urandom_range(0, 3) == 0);
`else
            bp = 1'b0;
`endif
            if (stop) begin
                exp_q.push_back(b);
                if (bp) exp_par++;
            end else begin
                exp_ferr++;
            end
            send_frame(b, stop, bp, blen, -1);
            if (!stop) idle(300);
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 40));
        end
        idle(20);
        check_errs("random");
        check("random_queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
